// File: rtl/seq_divider_8.sv
// Iterative radix-2 restoring divider: 2N-bit dividend / N-bit divisor, one quotient bit per clock.
// Start/ready/valid handshake; divide-by-zero and quotient overflow are resolved on the accepting edge.
module seq_divider_8 #(
    parameter int unsigned N = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             ready,
    output logic             valid,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder,
    output logic             dbz,
    output logic             ovf
);

    localparam int unsigned CW = $clog2(N);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CALC = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_ready;
    logic            r_valid;
    logic [N-1:0]    r_quot;
    logic [N-1:0]    r_rem;
    logic [N-1:0]    r_shift;
    logic [N-1:0]    r_div;
    logic [CW-1:0]   r_cnt;
    logic            r_dbz;
    logic            r_ovf;

    logic [N-1:0]    w_hi;
    logic [N:0]      w_t;
    logic [N:0]      w_diff;
    logic            w_ge;
    logic [N:0]      w_r_next;

    // One restoring step: shift next dividend bit into the partial remainder, trial-subtract at N+1 bits.
    assign w_hi     = dividend[2*N-1:N];
    assign w_t      = {r_rem, r_shift[N-1]};
    assign w_diff   = w_t - {1'b0, r_div};
    assign w_ge     = (w_t >= {1'b0, r_div});
    assign w_r_next = w_ge ? w_diff : w_t;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_valid <= 1'b0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_shift <= '0;
            r_div   <= '0;
            r_cnt   <= '0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (divisor == '0) begin
                            r_dbz  <= 1'b1;
                            r_ovf  <= 1'b0;
                            r_quot <= '1;
                            r_rem  <= '0;
                            r_valid <= 1'b1;
                        end else if (w_hi >= divisor) begin
                            r_dbz  <= 1'b0;
                            r_ovf  <= 1'b1;
                            r_quot <= '1;
                            r_rem  <= '0;
                            r_valid <= 1'b1;
                        end else begin
                            r_div   <= divisor;
                            r_rem   <= w_hi;
                            r_shift <= dividend[N-1:0];
                            r_cnt   <= CW'(N - 1);
                            r_dbz   <= 1'b0;
                            r_ovf   <= 1'b0;
                            r_ready <= 1'b0;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_rem   <= N'(w_r_next);
                    r_quot  <= {r_quot[N-2:0], w_ge};
                    r_shift <= {r_shift[N-2:0], 1'b0};
                    r_cnt   <= r_cnt - CW'(1);
                    // Last quotient bit resolved on this edge.
                    if (r_cnt == '0) begin
                        r_valid <= 1'b1;
                        r_ready <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready     = r_ready;
    assign valid     = r_valid;
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign dbz       = r_dbz;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_divider_8.sv
// Self-checking bench for seq_divider_8: directed cases, back-to-back and abort scenarios,
// multiplier cross-check and random operands against an arithmetic reference model.
module tb_seq_divider_8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        ready;
    logic        valid;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        dbz;
    logic        ovf;

    int checks = 0;
    int errors = 0;

    seq_divider_8 #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .valid     (valid),
        .quotient  (quotient),
        .remainder (remainder),
        .dbz       (dbz),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: plain integer division plus the two flag rules.
    task automatic model(input logic [15:0] a, input logic [7:0] b,
                         output logic [7:0] q, output logic [7:0] r,
                         output logic fz, output logic fo, output int lat);
        fz = 1'b0; fo = 1'b0;
        if (b == 8'd0) begin
            fz = 1'b1; q = 8'hFF; r = 8'd0; lat = 1;
        end else if ((a >> 8) >= 16'(b)) begin
            fo = 1'b1; q = 8'hFF; r = 8'd0; lat = 1;
        end else begin
            q = 8'(32'(a) / 32'(b));
            r = 8'(32'(a) % 32'(b));
            lat = 9;
        end
    endtask

    task automatic rand_legal(output logic [15:0] a, output logic [7:0] b);
        logic [7:0] hi;
        b  = 8'($urandom_range(1, 255));
        hi = 8'($urandom_range(0, 32'(b) - 1));
        a  = {hi, 8'($urandom)};
    endtask

    // Single operation with start pulsed for one cycle; checks latency, ready, results, valid pulse width.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input bit full);
        logic [7:0] eq, er;
        logic       ez, eo;
        int         lat, cyc;
        model(a, b, eq, er, ez, eo, lat);
        @(negedge clk);
        if (full) check("ready_idle", 32'(ready), 32'd1);
        dividend = a; divisor = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (valid) break;
            if (full) check("ready_busy", 32'(ready), 32'd0);
        end
        check("latency", 32'(cyc), 32'(lat));
        check("quotient", 32'(quotient), 32'(eq));
        check("remainder", 32'(remainder), 32'(er));
        check("dbz", 32'(dbz), 32'(ez));
        check("ovf", 32'(ovf), 32'(eo));
        if (!ez && !eo) begin
            check("inv_product", 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            check("inv_rem_lt", 32'(remainder < b), 32'd1);
        end
        if (full) begin
            check("ready_done", 32'(ready), 32'd1);
            @(negedge clk);
            check("valid_pulse", 32'(valid), 32'd0);
        end
    endtask

    initial begin
        logic [15:0] a;
        logic [7:0]  b, eq, er;
        logic        ez, eo;
        int          lat, cyc, nvalid;

        rst_n = 1'b0; start = 1'b0; dividend = '0; divisor = '0;

        // Reset held for two edges.
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_quot", 32'(quotient), 32'd0);
        check("rst_rem", 32'(remainder), 32'd0);
        check("rst_dbz", 32'(dbz), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        // Directed cases including boundaries and both exceptions.
        run_op(16'd12345, 8'd57, 1'b1);
        run_op(16'd65025, 8'd255, 1'b1);
        run_op(16'd255, 8'd1, 1'b1);
        run_op(16'd1000, 8'd0, 1'b1);
        run_op(16'h1234, 8'h12, 1'b1);
        run_op(16'h00FF, 8'hFF, 1'b1);
        run_op(16'h0100, 8'h01, 1'b1);

        // Back-to-back: start held high, next operands presented in each valid cycle.
        @(negedge clk);
        rand_legal(a, b);
        dividend = a; divisor = b; start = 1'b1;
        for (int k = 0; k < 6; k++) begin
            model(a, b, eq, er, ez, eo, lat);
            cyc = 0;
            while (cyc < 20) begin
                @(negedge clk);
                cyc++;
                if (valid) break;
            end
            check("b2b_period", 32'(cyc), 32'd9);
            check("b2b_quot", 32'(quotient), 32'(eq));
            check("b2b_rem", 32'(remainder), 32'(er));
            rand_legal(a, b);
            dividend = a; divisor = b;
        end
        start = 1'b0;
        @(negedge clk);

        // start pulses during CALC must be ignored.
        model(16'd40000, 8'd200, eq, er, ez, eo, lat);
        dividend = 16'd40000; divisor = 8'd200; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nvalid = 0; cyc = 0;
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 6) begin
                start = c[0]; dividend = 16'd7; divisor = 8'd3;
            end else begin
                start = 1'b0;
            end
            if (valid) begin
                nvalid++;
                if (cyc == 0) cyc = c;
            end
        end
        check("ignore_count", 32'(nvalid), 32'd1);
        check("ignore_lat", 32'(cyc), 32'd9);
        check("ignore_quot", 32'(quotient), 32'(eq));
        check("ignore_rem", 32'(remainder), 32'(er));

        // Reset at E4 aborts the operation.
        @(negedge clk);
        dividend = 16'd12345; divisor = 8'd57; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nvalid = 0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_valid", 32'(valid), 32'd0);
        rst_n = 1'b1;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (valid) nvalid++;
        end
        check("abort_novalid", 32'(nvalid), 32'd0);

        // Multiplier cross-check: (A*B)/B == A, remainder 0.
        for (int k = 0; k < 20; k++) begin
            logic [7:0] ma, mb;
            ma = 8'($urandom);
            mb = 8'($urandom_range(1, 255));
            run_op(16'(ma) * 16'(mb), mb, 1'b0);
            check("mul_quot", 32'(quotient), 32'(ma));
            check("mul_rem", 32'(remainder), 32'd0);
        end

        // Random operands: mostly legal, some unconstrained (exceptions included).
        for (int k = 0; k < 2000; k++) begin
            if ($urandom_range(0, 3) != 0) begin
                rand_legal(a, b);
            end else begin
                a = 16'($urandom);
                b = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            end
            run_op(a, b, (k % 50) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
